// File: rtl/gate_pkg.sv
// Shared types and helpers for the gate stimulus checker.
//   op_e          : gate function the checker expects (AND/OR/XOR/NAND)
//   state_e       : checker FSM states
//   gate_expected : golden response of the selected gate to inputs a, b
package gate_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic gate_expected(op_e op, logic a, logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_stim_checker.sv
// Exhaustive truth-table checker for a 2-input combinational gate.
// Drives all four input vectors onto a/b, waits SETTLE_CYC cycles per vector,
// samples the gate output c and counts mismatches against the expected function.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle run request, honoured only in IDLE
//   op_sel    in   expected gate function (0 AND, 1 OR, 2 XOR, 3 NAND)
//   a, b      out  gate inputs (vec_idx[1], vec_idx[0])
//   c         in   gate output under test
//   vec_idx   out  current vector index
//   busy      out  run in progress (SETTLE/CHECK/DONE)
//   done      out  one-cycle end-of-run pulse
//   pass      out  last completed run had no mismatches
//   err_count out  mismatch count of current/last run (0..4)
//
// state  | meaning
// IDLE   | waiting for start; outputs hold last run's result
// SETTLE | a/b stable, waiting SETTLE_CYC cycles for c to settle
// CHECK  | sample c, score the vector, advance or finish
// DONE   | one-cycle done pulse, result published
module gate_stim_checker
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op_sel,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_e     state, state_next;
  logic [1:0] vec_next;
  logic [3:0] settle_cnt, settle_next;
  logic [2:0] err_next;
  logic       pass_next;
  op_e        op_lat, op_next;
  logic       mismatch;
  logic [2:0] err_scored;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec_idx    <= 2'd0;
      settle_cnt <= 4'd0;
      err_count  <= 3'd0;
      pass       <= 1'b0;
      op_lat     <= OP_OR;
    end else begin
      state      <= state_next;
      vec_idx    <= vec_next;
      settle_cnt <= settle_next;
      err_count  <= err_next;
      pass       <= pass_next;
      op_lat     <= op_next;
    end
  end

  assign mismatch   = (c != gate_expected(op_lat, vec_idx[1], vec_idx[0]));
  // Saturate at 4 even though a single run cannot exceed it.
  assign err_scored = (mismatch && err_count < 3'd4) ? err_count + 3'd1 : err_count;

  always_comb begin
    state_next  = state;
    vec_next    = vec_idx;
    settle_next = settle_cnt;
    err_next    = err_count;
    pass_next   = pass;
    op_next     = op_lat;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next  = ST_SETTLE;
          vec_next    = 2'd0;
          settle_next = 4'd0;
          err_next    = 3'd0;
          pass_next   = 1'b0;
          op_next     = op_e'(op_sel);
        end
      end
      ST_SETTLE: begin
        settle_next = settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_LAST) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        err_next = err_scored;
        if (vec_idx != 2'd3) begin
          vec_next    = vec_idx + 2'd1;
          settle_next = 4'd0;
          state_next  = ST_SETTLE;
        end else begin
          // Publish the verdict together with the done pulse.
          pass_next  = (err_scored == 3'd0);
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign a    = vec_idx[1];
  assign b    = vec_idx[0];
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule
